// File: rtl/panel_sequencer.sv
// Front-panel sequencer: deposits switch data into memory (IN), examines memory (CHECK),
// or hands the shared memory bus to the CPU (RUN). The bus is steered combinationally from the FSM state.
module panel_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode_sel,
    input  logic        go,
    input  logic [7:0]  sw_data,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [7:0]  mem_din,
    output logic [1:0]  cpustate,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_dout,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] ptr,
    output logic [7:0]  disp_data,
    output logic        busy,
    output logic        done,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_IN_WAIT  = 3'd1,
        S_IN_WR    = 3'd2,
        S_IN_INC   = 3'd3,
        S_CHK_WAIT = 3'd4,
        S_CHK_RD   = 3'd5,
        S_CHK_CAP  = 3'd6,
        S_RUN      = 3'd7
    } state_e;

    state_e      state_q, state_d;
    state_e      target_state;
    logic        go_q;
    logic        go_rise;
    logic        mode_change;
    logic [15:0] ptr_q, ptr_d;
    logic [7:0]  disp_q, disp_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            go_q    <= 1'b0;
            ptr_q   <= 16'h0000;
            disp_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            go_q    <= go;
            ptr_q   <= ptr_d;
            disp_q  <= disp_d;
        end
    end

    assign go_rise   = go & ~go_q;
    assign ptr       = ptr_q;
    assign disp_data = disp_q;
    assign dbg_state = state_q;

    always_comb begin
        cpustate     = 2'b00;
        target_state = S_IDLE;
        case (state_q)
            S_IN_WAIT, S_IN_WR, S_IN_INC:    cpustate = 2'b01;
            S_CHK_WAIT, S_CHK_RD, S_CHK_CAP: cpustate = 2'b10;
            S_RUN:                           cpustate = 2'b11;
            default:                         cpustate = 2'b00;
        endcase
        case (mode_sel)
            2'b01:   target_state = S_IN_WAIT;
            2'b10:   target_state = S_CHK_WAIT;
            2'b11:   target_state = S_RUN;
            default: target_state = S_IDLE;
        endcase
    end

    // Mode switches are only honoured in the resting states, so a panel access always completes.
    assign mode_change = ((state_q == S_IDLE) || (state_q == S_IN_WAIT) ||
                          (state_q == S_CHK_WAIT) || (state_q == S_RUN)) &&
                         (mode_sel != cpustate);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        disp_d    = disp_q;
        mem_addr  = ptr_q;
        mem_dout  = sw_data;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IN_WAIT:  if (go_rise) state_d = S_IN_WR;
            S_IN_WR: begin
                mem_write = 1'b1;
                busy      = 1'b1;
                state_d   = S_IN_INC;
            end
            S_IN_INC: begin
                busy    = 1'b1;
                done    = 1'b1;
                ptr_d   = ptr_q + 16'h0001;
                state_d = S_IN_WAIT;
            end
            S_CHK_WAIT: if (go_rise) state_d = S_CHK_RD;
            S_CHK_RD: begin
                mem_read = 1'b1;
                busy     = 1'b1;
                state_d  = S_CHK_CAP;
            end
            S_CHK_CAP: begin
                busy    = 1'b1;
                done    = 1'b1;
                disp_d  = mem_din;
                ptr_d   = ptr_q + 16'h0001;
                state_d = S_CHK_WAIT;
            end
            S_RUN: begin
                // CPU owns the bus; a simultaneous read+write request resolves to the write.
                mem_addr  = cpu_addr;
                mem_dout  = cpu_dout;
                mem_write = cpu_write;
                mem_read  = cpu_read & ~cpu_write;
            end
            default: state_d = state_q;
        endcase
        if (mode_change) begin
            state_d = target_state;
            if ((target_state == S_IN_WAIT) || (target_state == S_CHK_WAIT))
                ptr_d = 16'h0000;
        end
    end

endmodule

// File: tb/tb_panel_sequencer.sv
// Directed bench for panel_sequencer: a negedge monitor pops expected bus writes/reads
// and post-access ptr/disp_data results from a queue filled by the stimulus.
module tb_panel_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode_sel;
    logic        go;
    logic [7:0]  sw_data;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_read, cpu_write;
    logic [7:0]  mem_din;
    logic [1:0]  cpustate;
    logic [15:0] mem_addr;
    logic [7:0]  mem_dout;
    logic        mem_read, mem_write;
    logic [15:0] ptr;
    logic [7:0]  disp_data;
    logic        busy, done;
    logic [2:0]  dbg_state;

    localparam logic [1:0] K_WR = 2'd1, K_RD = 2'd2, K_RES = 2'd3;
    localparam logic [2:0] ST_IN_WAIT = 3'd1, ST_CHK_WAIT = 3'd4, ST_RUN = 3'd7;

    int total = 0;
    int bad   = 0;
    logic [25:0] exp_q[$];
    logic        pend_done = 1'b0;
    logic [7:0]  mem [0:65535];

    panel_sequencer dut (
        .clk(clk), .rst(rst), .mode_sel(mode_sel), .go(go), .sw_data(sw_data),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .mem_din(mem_din), .cpustate(cpustate), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .mem_read(mem_read), .mem_write(mem_write), .ptr(ptr), .disp_data(disp_data),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // memory model: read data valid the cycle after mem_read
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_dout;
        if (mem_read) mem_din <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back({kind, a, d});
    endtask

    task automatic pop_check(input string name, input logic [1:0] kind,
                             input logic [15:0] a, input logic [7:0] d);
        logic [25:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: unexpected event addr=%0h data=%0h, expected none", name, a, d);
        end else begin
            e = exp_q.pop_front();
            check({name, " kind"}, 32'(kind), 32'(e[25:24]));
            check({name, " addr"}, 32'(a), 32'(e[23:8]));
            if (e[25:24] != K_RD) check({name, " data"}, 32'(d), 32'(e[7:0]));
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            if (pend_done) pop_check("result", K_RES, ptr, disp_data);
            if (mem_write) pop_check("bus_write", K_WR, mem_addr, mem_dout);
            if (mem_read)  pop_check("bus_read", K_RD, mem_addr, 8'h00);
            pend_done = done;
        end else begin
            pend_done = 1'b0;
        end
    end

    // driver tasks
    task automatic set_mode(input logic [1:0] m);
        @(negedge clk);
        #1 mode_sel = m;
        @(negedge clk);
    endtask

    task automatic press_go(input string name);
        @(negedge clk);
        #1 go = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check({name, " done"}, 32'(done), 32'd1);
        #1 go = 1'b0;
    endtask

    logic [7:0] load_data [0:2];

    initial begin
        load_data[0] = 8'hA5;
        load_data[1] = 8'h3C;
        load_data[2] = 8'h00;
        rst = 1'b0; mode_sel = 2'b00; go = 1'b0; sw_data = 8'h00;
        cpu_addr = 16'h0000; cpu_dout = 8'h00; cpu_read = 1'b0; cpu_write = 1'b0;
        mem_din = 8'h00;

        #12;
        check("rst cpustate", 32'(cpustate), 32'd0);
        check("rst ptr", 32'(ptr), 32'd0);
        check("rst disp", 32'(disp_data), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst strobes", 32'({mem_read, mem_write}), 32'd0);
        #10 rst = 1'b1;

        // load three bytes
        set_mode(2'b01);
        check("in cpustate", 32'(cpustate), 32'd1);
        check("in ptr", 32'(ptr), 32'd0);
        for (int i = 0; i < 3; i++) begin
            #1 sw_data = load_data[i];
            push(K_WR, 16'(i), load_data[i]);
            push(K_RES, 16'(i + 1), 8'h00);
            press_go("load");
        end
        @(negedge clk);
        check("load ptr", 32'(ptr), 32'h0003);

        // examine the first two bytes
        set_mode(2'b10);
        check("chk cpustate", 32'(cpustate), 32'd2);
        check("chk ptr clear", 32'(ptr), 32'd0);
        push(K_RD, 16'h0000, 8'h00);
        push(K_RES, 16'h0001, 8'hA5);
        press_go("chk0");
        push(K_RD, 16'h0001, 8'h00);
        push(K_RES, 16'h0002, 8'h3C);
        press_go("chk1");
        @(negedge clk);
        check("chk disp", 32'(disp_data), 32'h3C);
        check("chk ptr", 32'(ptr), 32'h0002);

        // pointer wrap
        set_mode(2'b01);
        #1 force dut.ptr_q = 16'hFFFF;
        @(negedge clk);
        #1 release dut.ptr_q;
        check("wrap preload", 32'(ptr), 32'hFFFF);
        sw_data = 8'h5A;
        push(K_WR, 16'hFFFF, 8'h5A);
        push(K_RES, 16'h0000, 8'h3C);
        press_go("wrap");
        @(negedge clk);
        check("wrap ptr", 32'(ptr), 32'h0000);

        // mode change and go edge together: mode wins
        #1 sw_data = 8'h77;
        push(K_WR, 16'h0000, 8'h77);
        push(K_RES, 16'h0001, 8'h3C);
        press_go("pre_coll");
        @(negedge clk);
        #1 mode_sel = 2'b10; go = 1'b1;
        @(negedge clk);
        check("coll state", 32'(dbg_state), 32'(ST_CHK_WAIT));
        check("coll ptr", 32'(ptr), 32'd0);
        check("coll busy", 32'(busy), 32'd0);
        #1 go = 1'b0;
        @(negedge clk);

        // mode change during IN_WR: write completes first
        set_mode(2'b01);
        #1 sw_data = 8'h11;
        push(K_WR, 16'h0000, 8'h11);
        push(K_RES, 16'h0001, 8'h3C);
        @(negedge clk);
        #1 go = 1'b1;
        @(negedge clk);
        #1 mode_sel = 2'b10;
        @(negedge clk);
        check("midwr done", 32'(done), 32'd1);
        #1 go = 1'b0;
        @(negedge clk);
        check("midwr back", 32'(dbg_state), 32'(ST_IN_WAIT));
        @(negedge clk);
        check("midwr chk", 32'(dbg_state), 32'(ST_CHK_WAIT));
        check("midwr ptr", 32'(ptr), 32'd0);

        // RUN pass-through
        #1 cpu_addr = 16'h1234; cpu_dout = 8'h99;
        set_mode(2'b11);
        check("run cpustate", 32'(cpustate), 32'd3);
        check("run addr", 32'(mem_addr), 32'h1234);
        push(K_WR, 16'h1234, 8'h99);
        #1 cpu_write = 1'b1;
        @(negedge clk);
        check("run write", 32'(mem_write), 32'd1);
        push(K_WR, 16'h1234, 8'h99);
        #1 cpu_read = 1'b1;
        @(negedge clk);
        check("run rd_blocked", 32'(mem_read), 32'd0);
        #1 cpu_read = 1'b0; cpu_write = 1'b0; go = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("run busy", 32'(busy), 32'd0);
            check("run done", 32'(done), 32'd0);
        end
        check("run state", 32'(dbg_state), 32'(ST_RUN));
        check("run ptr", 32'(ptr), 32'd0);
        check("run disp", 32'(disp_data), 32'h3C);
        #1 go = 1'b0;

        // reset during CHK_RD
        set_mode(2'b10);
        push(K_RD, 16'h0000, 8'h00);
        @(negedge clk);
        #1 go = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst strobes", 32'({mem_read, mem_write}), 32'd0);
        check("arst cpustate", 32'(cpustate), 32'd0);
        check("arst ptr", 32'(ptr), 32'd0);
        check("arst disp", 32'(disp_data), 32'd0);
        check("arst busy", 32'(busy), 32'd0);
        go = 1'b0; mode_sel = 2'b00;
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("queue empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
